// File: rtl/pipe_ctrl_unit.sv
// Pipeline control sequencer for the 3-stage RV32I core: stage-2 hold/bubble,
// next-PC select, and the machine-mode trap entry / MRET return sequence.
module pipe_ctrl_unit (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       dmem_wait_in,
  input  logic       branch_taken_in,
  input  logic       illegal_instr_in,
  input  logic       instr_misaligned_in,
  input  logic       ecall_in,
  input  logic       mret_in,
  input  logic       ext_irq_in,
  input  logic       mie_in,
  output logic       stall_out,
  output logic       flush_out,
  output logic [2:0] pc_src_out,
  output logic       trap_taken_out,
  output logic       mepc_wr_en_out,
  output logic       mie_clear_out,
  output logic       mie_restore_out,
  output logic [4:0] mcause_out
);

  // The PC mux owns BOOT_ADDRESS and applies it when PC_BOOT is selected.
  localparam logic [2:0] PC_BOOT   = 3'd0;
  localparam logic [2:0] PC_PLUS4  = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_TRAP   = 3'd3;
  localparam logic [2:0] PC_MEPC   = 3'd4;

  localparam logic [4:0] CAUSE_ILLEGAL    = 5'h02;
  localparam logic [4:0] CAUSE_MISALIGNED = 5'h00;
  localparam logic [4:0] CAUSE_ECALL      = 5'h0B;
  localparam logic [4:0] CAUSE_EXT_IRQ    = 5'h1B;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRAP  = 2'd2,
    ST_MRET  = 2'd3
  } state_t;

  state_t     state_q;
  logic [4:0] mcause_q;

  logic       run_active;
  logic       trap_req;
  logic       mret_req;
  logic       branch_req;
  logic [4:0] trap_cause;

  // Only the highest-priority event acts; the rest are dropped.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    branch_req = 1'b0;
    trap_cause = CAUSE_ILLEGAL;
    if (illegal_instr_in) begin
      trap_req   = 1'b1;
      trap_cause = CAUSE_ILLEGAL;
    end else if (instr_misaligned_in) begin
      trap_req   = 1'b1;
      trap_cause = CAUSE_MISALIGNED;
    end else if (ecall_in) begin
      trap_req   = 1'b1;
      trap_cause = CAUSE_ECALL;
    end else if (ext_irq_in && mie_in) begin
      trap_req   = 1'b1;
      trap_cause = CAUSE_EXT_IRQ;
    end else if (mret_in) begin
      mret_req   = 1'b1;
    end else if (branch_taken_in) begin
      branch_req = 1'b1;
    end
  end

  // Events are only honoured in RUN while data memory is ready.
  assign run_active = (state_q == ST_RUN) && !dmem_wait_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= ST_RESET;
      mcause_q <= 5'b0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_RUN;
        ST_RUN: begin
          if (run_active && trap_req) begin
            state_q  <= ST_TRAP;
            mcause_q <= trap_cause;
          end else if (run_active && mret_req) begin
            state_q  <= ST_MRET;
          end
        end
        ST_TRAP:  state_q <= ST_RUN;
        ST_MRET:  state_q <= ST_RUN;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

  // Hold, bubble and PC select depend on state plus this cycle's events.
  always_comb begin
    stall_out  = 1'b0;
    flush_out  = 1'b0;
    pc_src_out = PC_PLUS4;
    case (state_q)
      ST_RESET: begin
        flush_out  = 1'b1;
        pc_src_out = PC_BOOT;
      end
      ST_RUN: begin
        if (dmem_wait_in) begin
          stall_out = 1'b1;
        end else if (trap_req || mret_req) begin
          flush_out = 1'b1;
        end else if (branch_req) begin
          flush_out  = 1'b1;
          pc_src_out = PC_BRANCH;
        end
      end
      ST_TRAP: begin
        flush_out  = 1'b1;
        pc_src_out = PC_TRAP;
      end
      ST_MRET: begin
        flush_out  = 1'b1;
        pc_src_out = PC_MEPC;
      end
      default: begin
        flush_out  = 1'b1;
        pc_src_out = PC_BOOT;
      end
    endcase
  end

  // CSR-side strobes come from the state register alone, so they are glitch-free
  // and a reset during TRAP/MRET cannot stretch them.
  assign trap_taken_out  = (state_q == ST_TRAP);
  assign mepc_wr_en_out  = (state_q == ST_TRAP);
  assign mie_clear_out   = (state_q == ST_TRAP);
  assign mie_restore_out = (state_q == ST_MRET);
  assign mcause_out      = mcause_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl_unit;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       dmem_wait_in, branch_taken_in, illegal_instr_in, instr_misaligned_in;
  logic       ecall_in, mret_in, ext_irq_in, mie_in;
  logic       stall_out, flush_out, trap_taken_out, mepc_wr_en_out;
  logic       mie_clear_out, mie_restore_out;
  logic [2:0] pc_src_out;
  logic [4:0] mcause_out;

  int errors = 0;
  int checks = 0;

  // Model: what the previous edge left behind.
  bit       m_in_reset = 1'b1;
  int       m_pending  = 0;   // 0 = running, 3 = trap entry due, 4 = mret return due
  int       m_cause    = 0;

  pipe_ctrl_unit dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .dmem_wait_in        (dmem_wait_in),
    .branch_taken_in     (branch_taken_in),
    .illegal_instr_in    (illegal_instr_in),
    .instr_misaligned_in (instr_misaligned_in),
    .ecall_in            (ecall_in),
    .mret_in             (mret_in),
    .ext_irq_in          (ext_irq_in),
    .mie_in              (mie_in),
    .stall_out           (stall_out),
    .flush_out           (flush_out),
    .pc_src_out          (pc_src_out),
    .trap_taken_out      (trap_taken_out),
    .mepc_wr_en_out      (mepc_wr_en_out),
    .mie_clear_out       (mie_clear_out),
    .mie_restore_out     (mie_restore_out),
    .mcause_out          (mcause_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Returns the cause code of the winning exception/interrupt, -1 if none.
  function automatic int trap_cause();
    if (illegal_instr_in)        return 'h02;
    if (instr_misaligned_in)     return 'h00;
    if (ecall_in)                return 'h0B;
    if (ext_irq_in && mie_in)    return 'h1B;
    return -1;
  endfunction

  // Bits: {rst, wait, br, ill, mis, ecall, mret, irq, mie}
  task automatic drive(input logic [8:0] v);
    {reset_in, dmem_wait_in, branch_taken_in, illegal_instr_in, instr_misaligned_in,
     ecall_in, mret_in, ext_irq_in, mie_in} = v;
  endtask

  // One clock: compare outputs at the negedge, then advance the model at the posedge.
  task automatic step(input logic [8:0] v);
    int e_stall, e_flush, e_pc, e_trap, e_restore;
    drive(v);
    @(negedge clk_in);
    e_stall = 0; e_flush = 0; e_pc = 1; e_trap = 0; e_restore = 0;
    if (m_in_reset) begin
      e_flush = 1; e_pc = 0;
    end else if (m_pending == 3) begin
      e_flush = 1; e_pc = 3; e_trap = 1;
    end else if (m_pending == 4) begin
      e_flush = 1; e_pc = 4; e_restore = 1;
    end else if (dmem_wait_in) begin
      e_stall = 1;
    end else if (trap_cause() >= 0 || mret_in) begin
      e_flush = 1;
    end else if (branch_taken_in) begin
      e_flush = 1; e_pc = 2;
    end
    check("stall",       stall_out,       e_stall);
    check("flush",       flush_out,       e_flush);
    check("pc_src",      pc_src_out,      e_pc);
    check("trap_taken",  trap_taken_out,  e_trap);
    check("mepc_wr_en",  mepc_wr_en_out,  e_trap);
    check("mie_clear",   mie_clear_out,   e_trap);
    check("mie_restore", mie_restore_out, e_restore);
    check("mcause",      mcause_out,      m_cause);
    @(posedge clk_in);
    if (reset_in) begin
      m_in_reset = 1; m_pending = 0; m_cause = 0;
    end else if (m_in_reset || m_pending != 0) begin
      m_in_reset = 0; m_pending = 0;
    end else if (!dmem_wait_in) begin
      if (trap_cause() >= 0) begin
        m_pending = 3; m_cause = trap_cause();
      end else if (mret_in) begin
        m_pending = 4;
      end
    end
    #1;
  endtask

  localparam logic [8:0] RST   = 9'b1_0000_0000;
  localparam logic [8:0] IDLE  = 9'b0_0000_0000;
  localparam logic [8:0] WAIT  = 9'b0_1000_0000;
  localparam logic [8:0] BR    = 9'b0_0100_0000;
  localparam logic [8:0] ILL   = 9'b0_0010_0000;
  localparam logic [8:0] MIS   = 9'b0_0001_0000;
  localparam logic [8:0] ECALL = 9'b0_0000_1000;
  localparam logic [8:0] MRET  = 9'b0_0000_0100;
  localparam logic [8:0] IRQ   = 9'b0_0000_0010;
  localparam logic [8:0] MIE   = 9'b0_0000_0001;

  initial begin
    logic [8:0] r;
    // Bring the state register out of X before any comparison.
    drive(RST);
    @(posedge clk_in);
    #1;

    // Reset held three cycles, then released.
    repeat (3) step(RST);
    step(IDLE);
    step(IDLE);
    check("mcause_after_reset", mcause_out, 5'h00);

    // Single-cycle branch.
    step(BR);
    step(IDLE);

    // Illegal + ecall + irq together: illegal wins.
    step(ILL | ECALL | IRQ | MIE);
    check("mcause_illegal", mcause_out, 5'h02);
    check("pc_trap_vector", pc_src_out, 3'd3);
    step(IDLE);
    step(IDLE);

    // Misaligned beats ecall.
    step(MIS | ECALL);
    check("mcause_misaligned", mcause_out, 5'h00);
    step(IDLE);

    // Ecall alone.
    step(ECALL);
    check("mcause_ecall", mcause_out, 5'h0B);
    step(IDLE);

    // Stall holds off an illegal instruction, which then traps as soon as the wait drops.
    repeat (4) step(WAIT | ILL);
    step(ILL);
    step(IDLE);

    // Interrupt gated by mie, then taken.
    repeat (3) step(IRQ);
    step(IRQ | MIE);
    check("mcause_irq", mcause_out, 5'h1B);
    check("trap_pulse_irq", trap_taken_out, 1);
    step(IDLE);

    // Trap and MRET ignore stall and events on their own cycle.
    step(ECALL);
    step(WAIT | BR | ILL);
    step(IDLE);

    // MRET return sequence; a branch in the same cycle is dropped.
    step(MRET | BR);
    check("pc_mepc", pc_src_out, 3'd4);
    step(IDLE);
    step(IDLE);

    // Reset during TRAP and during MRET cuts the pulse.
    step(ILL);
    step(RST);
    step(RST);
    step(IDLE);
    step(MRET);
    step(RST);
    step(IDLE);
    step(IDLE);

    // Random traffic with sparse events.
    for (int i = 0; i < 400; i++) begin
      r = 9'b0;
      r[8] = ($urandom_range(0, 63) == 0);
      r[7] = ($urandom_range(0, 3) == 0);
      r[6] = ($urandom_range(0, 4) == 0);
      r[5] = ($urandom_range(0, 9) == 0);
      r[4] = ($urandom_range(0, 9) == 0);
      r[3] = ($urandom_range(0, 9) == 0);
      r[2] = ($urandom_range(0, 7) == 0);
      r[1] = ($urandom_range(0, 5) == 0);
      r[0] = ($urandom_range(0, 1) == 0);
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
